switch_box_config_loader: RTL
=============================

Name: switch_box_config_loader

Overview:
Configuration front-end for one universal switch box tile. Accepts configuration words over a valid/ready stream, assembles them into a shadow register of exactly the switch box's control width, and on an explicit commit transfers the whole image atomically to the `c` output that drives the switch box. The switch box therefore never sees a partially loaded image. Sits directly upstream of the switch box; one instance per tile.

Parameters:
- WS, 8, single-length track count of the driven switch box
- WD, 8, double-length track count; must be a multiple of 2
- DW, 8, configuration word width
- CFG_W (localparam), WS*6 + (WD/2)*6, switch box control width
- NWORDS (localparam), ceil(CFG_W/DW), words per frame

Ports:
- clk  input  1  clock
- rst  input  1  reset; synchronous, active-high
- cfg_start  input  1  begin a new frame; aborts any frame in progress
- cfg_valid  input  1  cfg_data is valid
- cfg_ready  output  1  loader accepts a word this cycle
- cfg_data  input  DW  configuration word
- cfg_commit  input  1  transfer the shadow image to c
- c  output  CFG_W  active switch box control bits
- loaded  output  1  shadow holds a complete frame
- err  output  1  sticky protocol error flag

Behaviour:
- Reset (rst=1 at a clk edge): c=0 (all switches open, so no tran shorts), shadow=0, state IDLE, word count=0, cfg_ready=0, loaded=0, err=0.
- States:
  - IDLE: cfg_ready=0.
  - LOAD: cfg_ready=1.
  - FULL: cfg_ready=0, loaded=1.
- Priority each cycle: rst > cfg_start > cfg_commit / data.
- cfg_start in any state:
  - state goes to LOAD, count goes to 0, err is cleared.
  - A word presented in the same cycle is dropped.
  - A commit in the same cycle is ignored.
  - Neither case sets err.
- LOAD, on cfg_valid & cfg_ready:
  - shadow[DW*cnt +: DW] is written with cfg_data; word 0 is the LSBs.
  - cnt increments.
  - On the NWORDS-th word, state goes to FULL.
  - Bits of the final word above CFG_W are discarded.
- FULL, on cfg_commit:
  - c <= shadow at that edge; new c is visible the cycle after commit is sampled.
  - state goes to IDLE.
  - All CFG_W bits change on the same edge.
- c changes only on a valid commit. Loading, aborts and errors never disturb c.
- Conditions that set err (the offending word or commit is otherwise ignored):
  - cfg_valid in IDLE or FULL.
  - cfg_commit in IDLE or LOAD.
- err stays high until cfg_start or rst.
- Shadow contents persist after a commit. A new frame overwrites every word, so no clear is needed.
- rst asserted mid-load: returns to the reset values above, including c=0.
- cnt width: $clog2(NWORDS+1). No wrap-around is possible, because cnt stops at NWORDS.

Decomposition:
- Shared package `sb_cfg_pkg` holds:
  - function `sb_cfg_width(WS,WD)` returning WS*6+WD/2*6, reused by the switch box instantiation and the bitstream tooling;
  - function `sb_cfg_words(width,DW)`;
  - state enum {IDLE, LOAD, FULL}.
- No sub-module is needed: a single FSM plus shadow and active registers.

Test Plan:
1. Reset with default parameters (CFG_W=72, NWORDS=9) -> c=0, cfg_ready=0, loaded=0, err=0.
2. cfg_start, then words 0x01..0x09 back-to-back, then cfg_commit:
   - cfg_ready drops and loaded=1 after the 9th accept;
   - c=72'h090807060504030201 one cycle after commit;
   - err=0.
3. Same frame with random cfg_valid gaps, plus cfg_valid held high in IDLE before start -> identical c; err=1 from the IDLE word until cfg_start clears it.
4. Commit after 5 words -> err=1, c unchanged. Send 4 more words, then commit -> c is updated and err stays 1.
5. Restart mid-frame:
   - frame 0xAA x4, then cfg_start, then 0xB0..0xB8 and commit -> c holds only the B-frame.
   - Separately, rst after 4 words -> c=0 and the state is IDLE.
6. Odd widths, WS=5, WD=2, DW=8 (CFG_W=36, NWORDS=5): words 0x11,0x22,0x33,0x44,0xF5, then commit -> c=36'h544332211, with the upper nibble of the last word discarded.

Source files
------------

// File: rtl/switch_box_config_loader_pkg.sv
// sb_cfg_pkg: shared sizing helpers and loader state encoding for switch box configuration
package sb_cfg_pkg;
   typedef enum logic [1:0] {IDLE, LOAD, FULL} sb_cfg_state_e;
   function automatic int sb_cfg_width(input int ws, input int wd);
      return ws*6 + wd/2*6;
   endfunction
   function automatic int sb_cfg_words(input int width, input int dw);
      return (width + dw - 1) / dw;
   endfunction
endpackage

// File: rtl/switch_box_config_loader.sv
// switch_box_config_loader: streams config words into a shadow image and commits it atomically to c
module switch_box_config_loader
   import sb_cfg_pkg::*;
#(
   parameter int WS = 8,
   parameter int WD = 8,
   parameter int DW = 8,
   localparam int CFG_W = sb_cfg_width(WS, WD),
   localparam int NWORDS = sb_cfg_words(CFG_W, DW)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cfg_start,
   input  logic             cfg_valid,
   output logic             cfg_ready,
   input  logic [DW-1:0]    cfg_data,
   input  logic             cfg_commit,
   output logic [CFG_W-1:0] c,
   output logic             loaded,
   output logic             err
);
   localparam int CW = $clog2(NWORDS + 1);
   localparam int SW = NWORDS * DW;
   sb_cfg_state_e state, state_n;
   logic [CW-1:0] cnt;
   logic [SW-1:0] shadow;
   logic accept, commit_ok, err_set;
   // next state and handshake decode; cfg_start overrides any word or commit in the same cycle
   always_comb begin
      state_n = state;
      accept = 1'b0;
      commit_ok = 1'b0;
      err_set = 1'b0;
      cfg_ready = state == LOAD;
      loaded = state == FULL;
      if (cfg_start) state_n = LOAD;
      else begin
         accept = cfg_valid && state == LOAD;
         commit_ok = cfg_commit && state == FULL;
         err_set = (cfg_valid && state != LOAD) || (cfg_commit && state != FULL);
         if (accept && cnt == CW'(NWORDS - 1)) state_n = FULL;
         if (commit_ok) state_n = IDLE;
      end
   end
   // state, word counter, shadow image, active image and sticky error
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt <= '0;
         shadow <= '0;
         c <= '0;
         err <= 1'b0;
      end else begin
         state <= state_n;
         if (cfg_start) begin
            cnt <= '0;
            err <= 1'b0;
         end else begin
            if (accept) begin
               shadow[DW*cnt +: DW] <= cfg_data;
               cnt <= cnt + 1'b1;
            end
            if (commit_ok) c <= shadow[CFG_W-1:0];
            if (err_set) err <= 1'b1;
         end
      end
   end
endmodule
